muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit sitting directly downstream of the register file read ports. It takes the two read-data operands of a MULT/MULTU/DIV/DIVU instruction, computes the 64-bit product or the quotient/remainder over 33 clock cycles, and holds the results in architectural HI/LO registers. Control logic reads these registers for MFHI/MFLO and writes them for MTHI/MTLO. It raises `busy` so the control logic can stall the pipeline while an operation is in flight.

## Interface
- `WIDTH`, 32, operand and HI/LO width. Iteration count equals `WIDTH`.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin an operation; sampled only when idle.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`  in  WIDTH  multiplicand or dividend (from `rd_1`).
- `src_b`  in  WIDTH  multiplier or divisor (from `rd_2`).
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; HI/LO have just been updated.

## Operation
- FSM states are IDLE, CALC and FIX.
  - IDLE to CALC on `start`. The block latches `op` and the operands.
  - For signed ops, operands are latched as absolute values, and the result signs are recorded.
  - The iteration counter is cleared to 0.
- CALC performs one iteration per cycle. After iteration `WIDTH`-1 it moves to FIX.
  - Multiply: shift-add on a 2·`WIDTH` accumulator.
  - Divide: restoring; shift the remainder left, trial-subtract the divisor, then set the quotient bit.
- FIX applies sign correction and writes HI/LO, then returns to IDLE.
  - Multiply: {HI,LO} is the 64-bit product. The product is negated if the operand signs differ (signed only).
  - Divide: LO is the quotient and HI is the remainder.
  - Signed divide: the quotient is negative if the operand signs differ. The remainder takes the sign of the dividend.
- Divide by zero (`src_b` = 0, either divide op): HI = `src_a` unchanged, LO = 0xFFFFFFFF.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This is a mod-2^32 wrap with no trap.
- MTHI/MTLO in IDLE: `hi_we` loads HI from `wdata`, and `lo_we` loads LO. Both may assert in the same cycle.
- `start` while busy is ignored. `hi_we`/`lo_we` while busy are ignored.
- `start` together with `hi_we`/`lo_we` in IDLE: `start` wins and the writes are dropped.
- `op`, `src_a` and `src_b` are don't-care except in the `start` cycle.

## Timing
- Reset (async assert, any state): FSM = IDLE, counter = 0, HI = 0, LO = 0, `busy` = 0, `done` = 0.
- Reset mid-operation aborts the operation, and HI/LO return to 0.
- Deassertion of `rst_n` is synchronised to `clk` externally.
- `start` is sampled at edge E0. `busy` = 1 from after E0 until E33; 33 busy cycles in total.
- CALC iterations occur on edges E1..E32. FIX is the cycle after E32, and the write happens at E33.
- At E33: HI/LO take their new values, `busy` falls to 0, and `done` = 1 for exactly the E33–E34 cycle.
- A new `start` is accepted from E33 onward, i.e. in the same cycle `done` is high.
- `hi` and `lo` are registered outputs with no combinational path from inputs. Between E0 and E33 they hold their previous values.
- MTHI/MTLO writes are visible on `hi`/`lo` one cycle after the write edge.

## Test plan
- Reset and basic multiply:
  - Stimulus: reset, then MTHI 0x12345678 and MTLO 0x9ABCDEF0.
  - Required: `hi`/`lo` read back these values; `busy` = 0 and `done` = 0 throughout.
- Signed multiply:
  - Stimulus: MULT 0xFFFFFFFE × 0x00000003.
  - Required: HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - Required: `busy` high for exactly 33 cycles; `done` high for exactly 1 cycle.
- Unsigned multiply:
  - Stimulus: MULTU 0xFFFFFFFF × 0xFFFFFFFF.
  - Required: HI = 0xFFFFFFFE, LO = 0x00000001.
- Divide:
  - Stimulus: DIV -7 / 2.
  - Required: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - Stimulus: DIVU 100 / 7.
  - Required: LO = 14, HI = 2.
- Divide corner cases:
  - Stimulus: DIVU 0x1234 / 0.
  - Required: HI = 0x1234, LO = 0xFFFFFFFF.
  - Stimulus: DIV 0x80000000 / 0xFFFFFFFF.
  - Required: LO = 0x80000000, HI = 0.
- Hazards:
  - Stimulus: `start` and `hi_we` pulsed mid-operation.
  - Required: both ignored.
  - Stimulus: `rst_n` low at cycle 10 of a MULT.
  - Required: HI = LO = 0 and `busy` = 0 immediately.
  - Stimulus: a new `start` issued on the `done` cycle.
  - Required: it is accepted.

Source files
------------

// File: rtl/muldiv_if.sv
// Request/result bundle between the control logic and the iterative multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One iteration per cycle on magnitudes; signs are restored in a single FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               sgn_q, sgn_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   raw_a_q, raw_a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     trial, diff;
    logic               no_borrow;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    // Even op codes are the signed variants.
    assign signed_op = ~bus.op[0];
    assign a_neg     = signed_op & bus.src_a[WIDTH-1];
    assign b_neg     = signed_op & bus.src_b[WIDTH-1];
    assign a_abs     = a_neg ? -bus.src_a : bus.src_a;
    assign b_abs     = b_neg ? -bus.src_b : bus.src_b;

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: remainder in the high half, quotient bits shift into the low half.
    assign trial     = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff      = trial - {1'b0, b_q};
    assign no_borrow = ~diff[WIDTH];
    assign div_next  = {(no_borrow ? diff[WIDTH-1:0] : trial[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], no_borrow};

    assign prod_fix = sgn_q  ? -acc_q : acc_q;
    assign q_fix    = sgn_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign r_fix    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sgn_d    = sgn_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        raw_a_d  = raw_a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    is_div_d = bus.op[1];
                    sgn_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    dz_d     = bus.op[1] & (bus.src_b == '0);
                    raw_a_d  = bus.src_a;
                    b_d      = b_abs;
                    acc_d    = {{WIDTH{1'b0}}, a_abs};
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (dz_q) begin
                    hi_d = raw_a_q;
                    lo_d = '1;
                end else begin
                    hi_d = r_fix;
                    lo_d = q_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sgn_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            raw_a_q  <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sgn_q    <= sgn_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            raw_a_q  <= raw_a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: result table plus hand-written hazard sequences.
module tb_muldiv_unit;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue start at the next negedge; returns at the negedge just after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op = ~o; bus.src_a = ~a; bus.src_b = ~b;
    endtask

    // Sample index 0 is the negedge right after the accepting edge; returns -1 on timeout.
    task automatic wait_done(output int idx);
        idx = -1;
        for (int i = 0; i < 60; i++) begin
            if (bus.done) begin
                idx = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic mt(input logic h, input logic l, input logic [31:0] d);
        @(negedge clk);
        bus.hi_we = h; bus.lo_we = l; bus.wdata = d;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = 32'h0;
    endtask

    initial begin
        int bc, dc, idx;
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
        vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
        vecs[9]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[10] = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[11] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[12] = '{2'b00, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        #12;
        chk("rst_hi",   bus.hi,   32'h0);
        chk("rst_lo",   bus.lo,   32'h0);
        chk("rst_busy", {31'b0, bus.busy}, 32'h0);
        chk("rst_done", {31'b0, bus.done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        mt(1'b1, 1'b0, 32'h12345678);
        chk("mthi_hi", bus.hi, 32'h12345678);
        chk("mthi_lo", bus.lo, 32'h0);
        mt(1'b0, 1'b1, 32'h9ABCDEF0);
        chk("mtlo_hi", bus.hi, 32'h12345678);
        chk("mtlo_lo", bus.lo, 32'h9ABCDEF0);
        chk("mt_busy", {31'b0, bus.busy}, 32'h0);
        chk("mt_done", {31'b0, bus.done}, 32'h0);
        mt(1'b1, 1'b1, 32'h0BADF00D);
        chk("mtboth_hi", bus.hi, 32'h0BADF00D);
        chk("mtboth_lo", bus.lo, 32'h0BADF00D);

        for (int v = 0; v < NV; v++) begin
            issue(vecs[v].op, vecs[v].a, vecs[v].b);
            bc = 0; dc = 0;
            for (int i = 0; i < 40; i++) begin
                if (bus.busy) bc++;
                if (bus.done) dc++;
                @(negedge clk);
            end
            chk($sformatf("vec%0d_hi", v), bus.hi, vecs[v].hi);
            chk($sformatf("vec%0d_lo", v), bus.lo, vecs[v].lo);
            chk($sformatf("vec%0d_busy_cycles", v), 32'(bc), 32'd33);
            chk($sformatf("vec%0d_done_cycles", v), 32'(dc), 32'd1);
        end

        // start with MTHI in IDLE: the write is dropped, HI holds until the result lands
        mt(1'b1, 1'b1, 32'h0000AAAA);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd3; bus.src_b = 32'd5;
        bus.hi_we = 1'b1; bus.wdata = 32'h00005555;
        @(negedge clk);
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.wdata = 32'h0;
        chk("startwin_hi",   bus.hi, 32'h0000AAAA);
        chk("startwin_busy", {31'b0, bus.busy}, 32'h1);
        for (int i = 0; i < 5; i++) @(negedge clk);
        // start and MTHI/MTLO while busy must have no effect
        bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd100; bus.src_b = 32'd7;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEADBEEF;
        @(negedge clk);
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = 32'h0;
        @(negedge clk);
        chk("busy_we_hi", bus.hi, 32'h0000AAAA);
        chk("busy_we_lo", bus.lo, 32'h0000AAAA);
        wait_done(idx);
        chk("busy_start_lat", 32'(idx + 7), 32'd33);
        chk("busy_res_hi", bus.hi, 32'd0);
        chk("busy_res_lo", bus.lo, 32'd15);

        // back-to-back: new start presented in the done cycle
        bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'h00000007; bus.src_b = 32'hFFFFFFFD;
        @(negedge clk);
        bus.start = 1'b0; bus.src_a = 32'h0; bus.src_b = 32'h0;
        chk("b2b_busy", {31'b0, bus.busy}, 32'h1);
        wait_done(idx);
        chk("b2b_lat", 32'(idx), 32'd33);
        chk("b2b_hi", bus.hi, 32'hFFFFFFFF);
        chk("b2b_lo", bus.lo, 32'hFFFFFFEB);

        // reset at cycle 10 of a MULT
        mt(1'b1, 1'b1, 32'h11112222);
        issue(2'b00, 32'h00001234, 32'h00005678);
        for (int i = 0; i < 10; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_hi",   bus.hi, 32'h0);
        chk("midrst_lo",   bus.lo, 32'h0);
        chk("midrst_busy", {31'b0, bus.busy}, 32'h0);
        chk("midrst_done", {31'b0, bus.done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'b11, 32'd100, 32'd7);
        wait_done(idx);
        chk("postrst_lat", 32'(idx), 32'd33);
        chk("postrst_hi", bus.hi, 32'd2);
        chk("postrst_lo", bus.lo, 32'd14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
